// File: rtl/punc_ctrl_mw_pkg.sv
// Shared encodings for the PUnC multi-cycle control slice: opcodes, FSM states,
// datapath mux selects and the bundled control-output word.
package punc_ctrl_mw_pkg;

  localparam logic [3:0] OP_BR   = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_LD   = 4'b0010;
  localparam logic [3:0] OP_ST   = 4'b0011;
  localparam logic [3:0] OP_JSR  = 4'b0100;
  localparam logic [3:0] OP_AND  = 4'b0101;
  localparam logic [3:0] OP_LDR  = 4'b0110;
  localparam logic [3:0] OP_STR  = 4'b0111;
  localparam logic [3:0] OP_RTI  = 4'b1000;
  localparam logic [3:0] OP_NOT  = 4'b1001;
  localparam logic [3:0] OP_LDI  = 4'b1010;
  localparam logic [3:0] OP_STI  = 4'b1011;
  localparam logic [3:0] OP_JMP  = 4'b1100;
  localparam logic [3:0] OP_RSV  = 4'b1101;
  localparam logic [3:0] OP_LEA  = 4'b1110;
  localparam logic [3:0] OP_HALT = 4'b1111;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM_I, S_MEM_D, S_HALT, S_FAULT
  } state_t;

  localparam logic [1:0] ADDR_PC    = 2'd0;
  localparam logic [1:0] ADDR_OFF9  = 2'd1;
  localparam logic [1:0] ADDR_BOFF6 = 2'd2;
  localparam logic [1:0] ADDR_MAR   = 2'd3;

  localparam logic [1:0] WSEL_ALU  = 2'd0;
  localparam logic [1:0] WSEL_MEM  = 2'd1;
  localparam logic [1:0] WSEL_PC   = 2'd2;
  localparam logic [1:0] WSEL_OFF9 = 2'd3;

  localparam logic [1:0] PCSRC_OFF9  = 2'd0;
  localparam logic [1:0] PCSRC_OFF11 = 2'd1;
  localparam logic [1:0] PCSRC_BASE  = 2'd2;

  localparam logic [1:0] ALU_ADD  = 2'd0;
  localparam logic [1:0] ALU_AND  = 2'd1;
  localparam logic [1:0] ALU_PASS = 2'd2;
  localparam logic [1:0] ALU_NOT  = 2'd3;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic [1:0] addr_sel;
    logic       ir_ld;
    logic       pc_inc;
    logic       pc_ld;
    logic [1:0] pc_src;
    logic       mar_ld;
    logic       rf_we;
    logic [2:0] rf_waddr;
    logic [2:0] rf_raddr0;
    logic [2:0] rf_raddr1;
    logic [1:0] rf_wsel;
    logic [1:0] alu_op;
    logic       alu_b_sel;
    logic       cc_ld;
    logic       cc_sel;
    logic       instr_retired;
    logic       halted;
    logic       fault;
  } ctrl_t;

  function automatic logic is_store(input logic [3:0] op);
    return (op == OP_ST) || (op == OP_STR) || (op == OP_STI);
  endfunction

  // Data-access address source once any indirection has been resolved into MAR.
  function automatic logic [1:0] mem_d_sel(input logic [3:0] op);
    case (op)
      OP_LDR, OP_STR: return ADDR_BOFF6;
      OP_LDI, OP_STI: return ADDR_MAR;
      default:        return ADDR_OFF9;
    endcase
  endfunction

endpackage

// File: rtl/punc_mem_timeout.sv
// Memory-access watchdog: counts unanswered request cycles and flags when the
// limit is reached while a request is still pending.
import punc_ctrl_mw_pkg::*;

module punc_mem_timeout #(
  parameter int TIMEOUT_CYC = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic busy,
  output logic expired
);

  localparam int CW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [CW-1:0] LIM = CW'(TIMEOUT_CYC);

  logic [CW-1:0] r_cnt;

  // Saturates at the limit so a stalled FSM never wraps back to a benign count.
  always_ff @(posedge clk) begin
    if (rst || clr)
      r_cnt <= '0;
    else if (busy && (r_cnt != LIM))
      r_cnt <= r_cnt + 1'b1;
  end

  assign expired = (TIMEOUT_CYC != 0) && busy && (r_cnt == LIM);

endmodule

// File: rtl/punc_ctrl_mw.sv
// PUnC LC3 multi-cycle control FSM with ready-handshaked memory, access
// timeout trap, debug single-step and a per-instruction retire pulse.
import punc_ctrl_mw_pkg::*;

module punc_ctrl_mw #(
  parameter int TIMEOUT_CYC = 64,
  parameter bit STEP_EN     = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] ir,
  input  logic        n,
  input  logic        z,
  input  logic        p,
  input  logic        mem_rdy,
  input  logic        dbg_step_mode,
  input  logic        dbg_step,
  output logic        mem_req,
  output logic        mem_we,
  output logic [1:0]  mem_addr_sel,
  output logic        ir_ld,
  output logic        pc_inc,
  output logic        pc_ld,
  output logic [1:0]  pc_src,
  output logic        mar_ld,
  output logic        rf_we,
  output logic [2:0]  rf_waddr,
  output logic [2:0]  rf_raddr0,
  output logic [2:0]  rf_raddr1,
  output logic [1:0]  rf_wsel,
  output logic [1:0]  alu_op,
  output logic        alu_b_sel,
  output logic        cc_ld,
  output logic        cc_sel,
  output logic        instr_retired,
  output logic        halted,
  output logic        fault
);

  state_t     r_state, w_next;
  ctrl_t      w_c, w_o;
  logic       r_step_pend;
  logic       w_step_hold, w_tmo, w_tmo_clr;
  logic [3:0] w_op;
  logic       w_unused;

  assign w_op        = ir[15:12];
  assign w_unused    = ^ir[4:3];
  assign w_step_hold = STEP_EN && dbg_step_mode && !r_step_pend;
  assign w_tmo_clr   = !w_c.mem_req || mem_rdy;

  punc_mem_timeout #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_tmo (
    .clk     (clk),
    .rst     (rst),
    .clr     (w_tmo_clr),
    .busy    (w_c.mem_req),
    .expired (w_tmo)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_FETCH;
    else     r_state <= w_next;
  end

  // A step pulse may land mid-instruction; hold it until the next fetch completes.
  always_ff @(posedge clk) begin
    if (rst)
      r_step_pend <= 1'b0;
    else if (STEP_EN && dbg_step)
      r_step_pend <= 1'b1;
    else if (w_c.ir_ld)
      r_step_pend <= 1'b0;
  end

  always_comb begin
    w_c    = '0;
    w_next = r_state;
    case (r_state)
      S_FETCH: begin
        if (!w_step_hold) begin
          w_c.mem_req  = 1'b1;
          w_c.addr_sel = ADDR_PC;
          if (w_tmo)
            w_next = S_FAULT;
          else if (mem_rdy) begin
            w_c.ir_ld  = 1'b1;
            w_c.pc_inc = 1'b1;
            w_next     = S_DECODE;
          end
        end
      end
      S_DECODE: begin
        w_c.rf_raddr0 = ir[8:6];
        w_c.rf_raddr1 = ir[2:0];
        case (w_op)
          OP_HALT:                     w_next = S_HALT;
          OP_RTI, OP_RSV:              w_next = S_FAULT;
          OP_LDI, OP_STI:              w_next = S_MEM_I;
          OP_LD, OP_LDR, OP_ST, OP_STR: w_next = S_MEM_D;
          default:                     w_next = S_EXEC;
        endcase
      end
      S_EXEC: begin
        w_c.instr_retired = 1'b1;
        w_next            = S_FETCH;
        case (w_op)
          OP_ADD, OP_AND, OP_NOT: begin
            w_c.alu_op    = (w_op == OP_ADD) ? ALU_ADD :
                            (w_op == OP_AND) ? ALU_AND : ALU_NOT;
            w_c.alu_b_sel = (w_op != OP_NOT) && ir[5];
            w_c.rf_we     = 1'b1;
            w_c.rf_waddr  = ir[11:9];
            w_c.rf_wsel   = WSEL_ALU;
            w_c.cc_ld     = 1'b1;
          end
          OP_BR: begin
            w_c.pc_ld  = (n & ir[11]) | (z & ir[10]) | (p & ir[9]);
            w_c.pc_src = PCSRC_OFF9;
          end
          OP_JMP: begin
            w_c.pc_ld  = 1'b1;
            w_c.pc_src = PCSRC_BASE;
          end
          OP_JSR: begin
            w_c.rf_we    = 1'b1;
            w_c.rf_waddr = 3'd7;
            w_c.rf_wsel  = WSEL_PC;
            w_c.pc_ld    = 1'b1;
            w_c.pc_src   = ir[11] ? PCSRC_OFF11 : PCSRC_BASE;
          end
          OP_LEA: begin
            w_c.rf_we    = 1'b1;
            w_c.rf_waddr = ir[11:9];
            w_c.rf_wsel  = WSEL_OFF9;
            w_c.cc_ld    = 1'b1;
          end
          default: ;
        endcase
      end
      S_MEM_I: begin
        w_c.mem_req  = 1'b1;
        w_c.addr_sel = ADDR_OFF9;
        if (w_tmo)
          w_next = S_FAULT;
        else if (mem_rdy) begin
          w_c.mar_ld = 1'b1;
          w_next     = S_MEM_D;
        end
      end
      S_MEM_D: begin
        w_c.mem_req  = 1'b1;
        w_c.addr_sel = mem_d_sel(w_op);
        if (is_store(w_op)) begin
          w_c.mem_we    = 1'b1;
          w_c.rf_raddr0 = ir[11:9];
        end
        if (w_tmo)
          w_next = S_FAULT;
        else if (mem_rdy) begin
          if (!is_store(w_op)) begin
            w_c.rf_we    = 1'b1;
            w_c.rf_waddr = ir[11:9];
            w_c.rf_wsel  = WSEL_MEM;
            w_c.cc_ld    = 1'b1;
            w_c.cc_sel   = 1'b1;
          end
          w_c.instr_retired = 1'b1;
          w_next            = S_FETCH;
        end
      end
      S_HALT:  w_c.halted = 1'b1;
      S_FAULT: w_c.fault  = 1'b1;
      default: w_next = S_FETCH;
    endcase
  end

  // Reset cycle forces every control line low, so a reset mid-access writes nothing.
  assign w_o = rst ? '0 : w_c;

  assign mem_req       = w_o.mem_req;
  assign mem_we        = w_o.mem_we;
  assign mem_addr_sel  = w_o.addr_sel;
  assign ir_ld         = w_o.ir_ld;
  assign pc_inc        = w_o.pc_inc;
  assign pc_ld         = w_o.pc_ld;
  assign pc_src        = w_o.pc_src;
  assign mar_ld        = w_o.mar_ld;
  assign rf_we         = w_o.rf_we;
  assign rf_waddr      = w_o.rf_waddr;
  assign rf_raddr0     = w_o.rf_raddr0;
  assign rf_raddr1     = w_o.rf_raddr1;
  assign rf_wsel       = w_o.rf_wsel;
  assign alu_op        = w_o.alu_op;
  assign alu_b_sel     = w_o.alu_b_sel;
  assign cc_ld         = w_o.cc_ld;
  assign cc_sel        = w_o.cc_sel;
  assign instr_retired = w_o.instr_retired;
  assign halted        = w_o.halted;
  assign fault         = w_o.fault;

endmodule

// File: tb/tb_punc_ctrl_mw.sv
// Directed bench for punc_ctrl_mw: hand-computed control vectors per cycle,
// run with a 4-cycle memory timeout so the fault path is reachable quickly.
module tb_punc_ctrl_mw;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] ir;
  logic        n, z, p, mem_rdy, dbg_step_mode, dbg_step;
  logic        mem_req, mem_we, ir_ld, pc_inc, pc_ld, mar_ld, rf_we;
  logic [1:0]  mem_addr_sel, pc_src, rf_wsel, alu_op;
  logic [2:0]  rf_waddr, rf_raddr0, rf_raddr1;
  logic        alu_b_sel, cc_ld, cc_sel, instr_retired, halted, fault;

  int errs = 0;
  int chks = 0;
  int rets = 0;
  int r0;

  punc_ctrl_mw #(.TIMEOUT_CYC(4), .STEP_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .ir(ir), .n(n), .z(z), .p(p), .mem_rdy(mem_rdy),
    .dbg_step_mode(dbg_step_mode), .dbg_step(dbg_step),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel),
    .ir_ld(ir_ld), .pc_inc(pc_inc), .pc_ld(pc_ld), .pc_src(pc_src),
    .mar_ld(mar_ld), .rf_we(rf_we), .rf_waddr(rf_waddr),
    .rf_raddr0(rf_raddr0), .rf_raddr1(rf_raddr1), .rf_wsel(rf_wsel),
    .alu_op(alu_op), .alu_b_sel(alu_b_sel), .cc_ld(cc_ld), .cc_sel(cc_sel),
    .instr_retired(instr_retired), .halted(halted), .fault(fault)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (instr_retired) rets++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic nx();
    @(posedge clk); #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic do_rst();
    rst = 1'b1; mem_rdy = 1'b0; dbg_step = 1'b0;
    nx();
    rst = 1'b0;
  endtask

  // Fetch with immediate ready, then step through DECODE; caller lands in the next state.
  task automatic fetch_dec(input logic [15:0] v);
    ir = v; mem_rdy = 1'b1;
    smp(); chk("fd_irld", ir_ld, 1);
    nx(); nx();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: sim time expired");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; ir = 16'h12BD; n = 0; z = 0; p = 0;
    mem_rdy = 1'b1; dbg_step_mode = 1'b0; dbg_step = 1'b0;
    nx();
    smp();
    chk("rst_req", mem_req, 0); chk("rst_irld", ir_ld, 0);
    chk("rst_halt", halted, 0); chk("rst_fault", fault, 0);
    nx(); rst = 1'b0;

    // ADD R1,R2,#-3
    r0 = rets;
    smp();
    chk("add_f_req", mem_req, 1); chk("add_f_sel", mem_addr_sel, 0);
    chk("add_f_irld", ir_ld, 1);  chk("add_f_pcinc", pc_inc, 1);
    nx(); smp();
    chk("add_d_ra0", rf_raddr0, 2); chk("add_d_ra1", rf_raddr1, 5);
    chk("add_d_we", rf_we, 0);      chk("add_d_req", mem_req, 0);
    nx(); smp();
    chk("add_e_we", rf_we, 1);   chk("add_e_wa", rf_waddr, 1);
    chk("add_e_bsel", alu_b_sel, 1); chk("add_e_op", alu_op, 0);
    chk("add_e_cc", cc_ld, 1);   chk("add_e_ccs", cc_sel, 0);
    chk("add_e_wsel", rf_wsel, 0); chk("add_e_ret", instr_retired, 1);
    nx(); smp();
    chk("add_back_irld", ir_ld, 1); chk("add_rets", rets - r0, 1);

    // LDI R4 with two wait cycles on each data access
    do_rst(); r0 = rets;
    ir = 16'hA805; mem_rdy = 1'b1;
    smp(); chk("ldi_irld", ir_ld, 1);
    nx(); mem_rdy = 1'b0;
    smp(); chk("ldi_dec_req", mem_req, 0);
    nx(); smp();
    chk("ldi_i_req", mem_req, 1); chk("ldi_i_sel", mem_addr_sel, 1); chk("ldi_i_w1", mar_ld, 0);
    nx(); smp(); chk("ldi_i_w2", mar_ld, 0);
    nx(); mem_rdy = 1'b1;
    smp(); chk("ldi_mar", mar_ld, 1);
    nx(); mem_rdy = 1'b0;
    smp(); chk("ldi_d_sel", mem_addr_sel, 3); chk("ldi_d_w1", rf_we, 0); chk("ldi_d_ret0", instr_retired, 0);
    nx(); smp(); chk("ldi_d_w2", rf_we, 0);
    nx(); mem_rdy = 1'b1;
    smp();
    chk("ldi_we", rf_we, 1); chk("ldi_wa", rf_waddr, 4); chk("ldi_wsel", rf_wsel, 1);
    chk("ldi_cc", cc_ld, 1); chk("ldi_ccs", cc_sel, 1); chk("ldi_ret", instr_retired, 1);
    nx(); smp();
    chk("ldi_back", ir_ld, 1); chk("ldi_rets", rets - r0, 1);

    // Branches and jumps
    do_rst();
    z = 0; fetch_dec(16'h0405); smp();
    chk("brz0_ld", pc_ld, 0); chk("brz0_ret", instr_retired, 1);
    nx(); z = 1; fetch_dec(16'h0405); smp();
    chk("brz1_ld", pc_ld, 1); chk("brz1_src", pc_src, 0);
    nx(); fetch_dec(16'h0805); smp();
    chk("brn_z_ld", pc_ld, 0);
    nx(); z = 0; fetch_dec(16'h4803); smp();
    chk("jsr_we", rf_we, 1); chk("jsr_wa", rf_waddr, 7); chk("jsr_wsel", rf_wsel, 2);
    chk("jsr_ld", pc_ld, 1); chk("jsr_src", pc_src, 1);
    nx(); fetch_dec(16'h40C0); smp();
    chk("jsrr_src", pc_src, 2); chk("jsrr_we", rf_we, 1);
    nx(); fetch_dec(16'hC1C0); smp();
    chk("jmp_ld", pc_ld, 1); chk("jmp_src", pc_src, 2); chk("jmp_we", rf_we, 0);
    nx(); fetch_dec(16'hE605); smp();
    chk("lea_wa", rf_waddr, 3); chk("lea_wsel", rf_wsel, 3); chk("lea_cc", cc_ld, 1);
    nx(); fetch_dec(16'h94FF); smp();
    chk("not_op", alu_op, 3); chk("not_wa", rf_waddr, 2); chk("not_we", rf_we, 1);

    // ST and LDR with immediate ready
    nx(); fetch_dec(16'h3605); smp();
    chk("st_we", mem_we, 1); chk("st_sel", mem_addr_sel, 1); chk("st_ra0", rf_raddr0, 3);
    chk("st_rfwe", rf_we, 0); chk("st_ret", instr_retired, 1);
    nx(); fetch_dec(16'h6885); smp();
    chk("ldr_sel", mem_addr_sel, 2); chk("ldr_we", rf_we, 1); chk("ldr_wa", rf_waddr, 4);
    chk("ldr_mwe", mem_we, 0);

    // Timeout in FETCH with ready stuck low
    do_rst(); ir = 16'h12BD; mem_rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      smp(); chk("tmo_req", mem_req, 1); chk("tmo_nofault", fault, 0);
      nx();
    end
    smp(); chk("tmo_fault", fault, 1); chk("tmo_req_off", mem_req, 0);
    mem_rdy = 1'b1;
    repeat (3) nx();
    smp(); chk("tmo_sticky", fault, 1); chk("tmo_noirld", ir_ld, 0);

    // Ready one cycle before the limit still completes; at the limit timeout wins
    do_rst(); mem_rdy = 1'b0;
    repeat (3) nx();
    mem_rdy = 1'b1; smp(); chk("tmo_lim_m1_irld", ir_ld, 1);
    nx(); smp(); chk("tmo_lim_m1_ok", fault, 0);
    do_rst(); mem_rdy = 1'b0;
    repeat (4) nx();
    mem_rdy = 1'b1; smp(); chk("tmo_lim_irld", ir_ld, 0);
    nx(); smp(); chk("tmo_lim_fault", fault, 1);

    // Single-step mode
    dbg_step_mode = 1'b1; do_rst(); r0 = rets;
    ir = 16'h12BD; mem_rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      smp(); chk("step_idle", mem_req, 0); nx();
    end
    dbg_step = 1'b1; smp(); chk("step_pulse_req", mem_req, 0);
    nx(); dbg_step = 1'b0;
    smp(); chk("step_f1_req", mem_req, 1); chk("step_f1_irld", ir_ld, 1);
    nx(); nx();
    dbg_step = 1'b1; smp(); chk("step_e1_ret", instr_retired, 1);
    nx(); dbg_step = 1'b0;
    smp(); chk("step_f2_irld", ir_ld, 1);
    nx(); nx(); smp(); chk("step_e2_ret", instr_retired, 1);
    nx(); smp(); chk("step_hold", mem_req, 0); chk("step_rets", rets - r0, 2);
    dbg_step_mode = 1'b0;

    // HALT and reserved opcode
    do_rst(); fetch_dec(16'hF025); smp();
    chk("halt_set", halted, 1); chk("halt_req", mem_req, 0);
    repeat (5) nx();
    smp(); chk("halt_sticky", halted, 1); chk("halt_ret", instr_retired, 0);
    do_rst(); fetch_dec(16'hD000); smp();
    chk("rsv_fault", fault, 1); chk("rsv_halt", halted, 0);

    // Reset during the MEM_D write of STI
    do_rst(); ir = 16'hB602; mem_rdy = 1'b1;
    smp(); chk("sti_irld", ir_ld, 1);
    nx(); nx();
    smp(); chk("sti_mar", mar_ld, 1);
    nx(); mem_rdy = 1'b0;
    smp(); chk("sti_we", mem_we, 1); chk("sti_sel", mem_addr_sel, 3); chk("sti_ra0", rf_raddr0, 3);
    nx(); rst = 1'b1;
    smp(); chk("sti_rst_we", mem_we, 0); chk("sti_rst_req", mem_req, 0);
    nx(); rst = 1'b0;
    smp(); chk("sti_after_req", mem_req, 1); chk("sti_after_sel", mem_addr_sel, 0);
    chk("sti_after_we", mem_we, 0); chk("sti_after_rfwe", rf_we, 0);

    $display("Result: errors=%0d of %0d checks", errs, chks);
    $finish;
  end

endmodule
